midi_message_decoder: RTL and testbench

//  Turns the MIDI byte stream from the UART receiver into note-change and control-change events. Supports running status, a channel mask and

---
 rtl/midi_message_decoder_pkg.sv | 59 +++++
 rtl/midi_message_decoder_event_reg.sv | 38 +++
 rtl/midi_message_decoder.sv | 108 ++++++++++
 tb/tb_midi_message_decoder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_message_decoder_pkg.sv
// Shared MIDI constants, event types and the parser state encoding used by
// the decoder and its output register.
package MIDI;

  localparam logic [3:0] STATUS_NOTE_OFF      = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON       = 4'h9;
  localparam logic [3:0] STATUS_CC            = 4'hB;
  localparam logic [3:0] STATUS_PROGRAM       = 4'hC;
  localparam logic [3:0] STATUS_CHAN_PRESSURE = 4'hD;
  localparam logic [7:0] SYSEX_START          = 8'hF0;
  localparam logic [7:0] REALTIME_MIN         = 8'hF8;

  typedef logic [6:0] note_t;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_status_t;

  typedef enum logic [6:0] {
    CTRL_21 = 7'd21,
    CTRL_22 = 7'd22,
    CTRL_24 = 7'd24,
    CTRL_25 = 7'd25,
    CTRL_26 = 7'd26,
    CTRL_27 = 7'd27,
    CTRL_28 = 7'd28
  } controller_t;

  typedef struct packed {
    note_status_t status;
    note_t        note_number;
    note_t        velocity;
  } note_change_t;

  typedef struct packed {
    note_t controller_number;
    note_t value;
  } control_change_t;

  typedef struct packed {
    logic            is_cc;
    logic [3:0]      channel;
    note_change_t    note;
    control_change_t cc;
  } midi_event_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SYSEX
  } decoder_state_t;

  function automatic logic is_known_controller(input note_t number);
    return number inside {7'd21, 7'd22, [7'd24:7'd28]};
  endfunction

endpackage

// File: rtl/midi_message_decoder_event_reg.sv
// One-entry valid/ready output register; a new event that finds it full and
// not being drained is dropped and flagged in a sticky overflow bit.
module midi_event_reg
  import MIDI::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  midi_event_t load_event,
  input  logic        out_ready,
  input  logic        clear_overflow,
  output logic        out_valid,
  output midi_event_t out_event,
  output logic        overflow
);

  // A drain and a load on the same edge replace the held event without loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_event <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load_valid && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_event <= load_event;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clear_overflow) begin
        overflow <= 1'b0;
      end else if (load_valid && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_message_decoder.sv
// MIDI byte-stream parser: tracks running status, skips real-time and SysEx
// traffic, and turns complete note/CC messages into output events.
module midi_message_decoder
  import MIDI::*;
#(
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter bit          CC_FILTER_EN = 1'b1,
  parameter int          NOTE_OFFSET  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_cc,
  output logic [3:0]      out_channel,
  output note_change_t    note_change,
  output control_change_t control_change,
  output logic            overflow,
  input  logic            clear_overflow
);

  localparam note_t OFFSET = note_t'(NOTE_OFFSET);

  decoder_state_t state;
  logic [3:0]     rs_type;
  logic [3:0]     rs_channel;
  note_t          d1;

  logic           complete;
  logic           emit;
  midi_event_t    new_event;
  midi_event_t    held_event;

  // The event is built from the byte being strobed so it lands one edge later.
  always_comb begin
    new_event = '0;
    emit      = 1'b0;
    complete  = byte_valid && !byte_data[7] && (state == WAIT_D2);
    new_event.channel = rs_channel;
    case (rs_type)
      STATUS_NOTE_ON, STATUS_NOTE_OFF: begin
        new_event.note.status      = (rs_type == STATUS_NOTE_ON && byte_data[6:0] != 7'd0)
                                     ? NOTE_ON : NOTE_OFF;
        new_event.note.note_number = d1 + OFFSET;
        new_event.note.velocity    = byte_data[6:0];
        emit = complete && CHANNEL_MASK[rs_channel];
      end
      STATUS_CC: begin
        new_event.is_cc = 1'b1;
        new_event.cc    = '{controller_number: d1, value: byte_data[6:0]};
        emit = complete && CHANNEL_MASK[rs_channel] &&
               (!CC_FILTER_EN || is_known_controller(d1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rs_type    <= 4'h0;
      rs_channel <= 4'h0;
      d1         <= '0;
    end else if (byte_valid) begin
      if (byte_data >= REALTIME_MIN) begin
        state <= state;
      end else if (byte_data == SYSEX_START) begin
        state <= SYSEX;
      end else if (byte_data[7:4] == 4'hF) begin
        state <= IDLE;
      end else if (byte_data[7]) begin
        rs_type    <= byte_data[7:4];
        rs_channel <= byte_data[3:0];
        state      <= WAIT_D1;
      end else begin
        case (state)
          WAIT_D1: begin
            d1    <= byte_data[6:0];
            state <= (rs_type == STATUS_PROGRAM || rs_type == STATUS_CHAN_PRESSURE)
                     ? WAIT_D1 : WAIT_D2;
          end
          WAIT_D2: state <= WAIT_D1;
          default: state <= state;
        endcase
      end
    end
  end

  midi_event_reg u_event_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (emit),
    .load_event     (new_event),
    .out_ready      (out_ready),
    .clear_overflow (clear_overflow),
    .out_valid      (out_valid),
    .out_event      (held_event),
    .overflow       (overflow)
  );

  assign out_is_cc      = held_event.is_cc;
  assign out_channel    = held_event.channel;
  assign note_change    = held_event.note;
  assign control_change = held_event.cc;

endmodule

// File: tb/tb_midi_message_decoder.sv
// Randomised and directed bench for two decoder configurations sharing one
// byte stream, compared against a message-level reference model.
module tb_midi_message_decoder;
  import MIDI::*;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        out_ready;
  logic        clear_overflow;

  logic            out_valid0, out_is_cc0, overflow0;
  logic [3:0]      out_channel0;
  note_change_t    note_change0;
  control_change_t control_change0;
  logic            out_valid1, out_is_cc1, overflow1;
  logic [3:0]      out_channel1;
  note_change_t    note_change1;
  control_change_t control_change1;

  int checks = 0;
  int errors = 0;

  midi_message_decoder dut0 (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_is_cc(out_is_cc0),
    .out_channel(out_channel0), .note_change(note_change0),
    .control_change(control_change0), .overflow(overflow0),
    .clear_overflow(clear_overflow)
  );

  midi_message_decoder #(
    .CHANNEL_MASK(16'h0001), .CC_FILTER_EN(1'b0), .NOTE_OFFSET(70)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_is_cc(out_is_cc1),
    .out_channel(out_channel1), .note_change(note_change1),
    .control_change(control_change1), .overflow(overflow1),
    .clear_overflow(clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [35:0] obs [2];
  assign obs[0] = {out_valid0, overflow0, out_is_cc0, out_channel0, note_change0, control_change0};
  assign obs[1] = {out_valid1, overflow1, out_is_cc1, out_channel1, note_change1, control_change1};

  // Reference model: running status byte plus a count of buffered data bytes.
  typedef struct {
    int          rs;
    int          nbuf;
    int          d1;
    bit          valid;
    bit          ovf;
    bit [33:0]   ev;
  } model_t;

  model_t m [2];

  function automatic model_t model_step(model_t s, bit [15:0] mask, bit filt, int off,
                                        bit rstn, bit bv, bit [7:0] b, bit rdy, bit clr);
    model_t    n = s;
    bit        have = 1'b0;
    bit [33:0] ev = '0;
    int        typ;
    int        ch;
    if (!rstn) begin
      n.rs = -1; n.nbuf = 0; n.d1 = 0; n.valid = 0; n.ovf = 0; n.ev = '0;
      return n;
    end
    if (bv) begin
      if (b >= 8'hF8) begin
        have = 1'b0;
      end else if (b >= 8'hF0) begin
        n.rs = -1; n.nbuf = 0;
      end else if (b >= 8'h80) begin
        n.rs = int'(b); n.nbuf = 0;
      end else if (n.rs >= 0) begin
        typ = n.rs / 16;
        ch  = n.rs % 16;
        if (n.nbuf == 0) begin
          if (typ != 12 && typ != 13) begin
            n.d1 = int'(b); n.nbuf = 1;
          end
        end else begin
          n.nbuf = 0;
          if (mask[ch]) begin
            if (typ == 8 || typ == 9) begin
              have = 1'b1;
              ev = {1'b0, 4'(ch), (typ == 9 && b != 0) ? 1'b1 : 1'b0,
                    7'((n.d1 + off) % 128), b[6:0], 14'd0};
            end else if (typ == 11 && (!filt || n.d1 inside {21, 22, 24, 25, 26, 27, 28})) begin
              have = 1'b1;
              ev = {1'b1, 4'(ch), 15'd0, 7'(n.d1), b[6:0]};
            end
          end
        end
      end
    end
    if (have) begin
      if (!s.valid || rdy) begin
        n.valid = 1'b1; n.ev = ev;
      end else begin
        n.ovf = 1'b1;
      end
    end else if (s.valid && rdy) begin
      n.valid = 1'b0;
    end
    if (clr) n.ovf = 1'b0;
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= model_step(m[0], 16'hFFFF, 1'b1, 0,  rst_n, byte_valid, byte_data, out_ready, clear_overflow);
    m[1] <= model_step(m[1], 16'h0001, 1'b0, 70, rst_n, byte_valid, byte_data, out_ready, clear_overflow);
  end

  function automatic bit [35:0] expv(int k);
    return {m[k].valid, m[k].ovf, m[k].ev};
  endfunction

  function automatic bit [35:0] note_vec(bit ovf, bit [3:0] ch, bit on, bit [6:0] note, bit [6:0] vel);
    return {1'b1, ovf, 1'b0, ch, on, note, vel, 14'd0};
  endfunction

  task automatic send_byte(input bit [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    out_ready = 1'b1; clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 36'd0) begin
        errors++; $display("[TB] FAIL reset_outputs inst%0d: got %h expected 0", k, obs[k]);
      end
    end
    checks++;
    if (dut0.state !== IDLE) begin
      errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut0.state, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit [7:0] seq [3] = '{8'h90, 8'h3C, 8'h64};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(seq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++; $display("[TB] FAIL basic inst%0d byte%0d: got %h expected %h", k, i, obs[k], expv(k));
        end
      end
      if (i == 1) begin
        checks++;
        if (out_valid0 !== 1'b0) begin
          errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid0);
        end
      end
    end
    checks++;
    if (obs[0] !== note_vec(1'b0, 4'd0, 1'b1, 7'd60, 7'd100)) begin
      errors++; $display("[TB] FAIL basic_event: got %h expected %h", obs[0], note_vec(1'b0, 4'd0, 1'b1, 7'd60, 7'd100));
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_accept: got %b expected 0", out_valid0);
    end
  endtask

  task automatic test_running_status;
    bit [7:0] seq [8] = '{8'h91, 8'h40, 8'h50, 8'h40, 8'h00, 8'h81, 8'h3C, 8'h7F};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++; $display("[TB] FAIL running inst%0d byte%0d: got %h expected %h", k, i, obs[k], expv(k));
        end
      end
      if (i == 2 || i == 4 || i == 7) begin
        bit [35:0] want;
        want = (i == 2) ? note_vec(1'b0, 4'd1, 1'b1, 7'd64, 7'd80) :
               (i == 4) ? note_vec(1'b0, 4'd1, 1'b0, 7'd64, 7'd0) :
                          note_vec(1'b0, 4'd1, 1'b0, 7'd60, 7'd127);
        checks++;
        if (obs[0] !== want) begin
          errors++; $display("[TB] FAIL running_event byte%0d: got %h expected %h", i, obs[0], want);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_interleave;
    bit [7:0] seq [10] = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64, 8'h90, 8'h3C, 8'hF3, 8'h64, 8'h64};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(seq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++; $display("[TB] FAIL interleave inst%0d byte%0d: got %h expected %h", k, i, obs[k], expv(k));
        end
      end
      if (i == 4) begin
        checks++;
        if (obs[0] !== note_vec(1'b0, 4'd0, 1'b1, 7'd60, 7'd100)) begin
          errors++; $display("[TB] FAIL interleave_realtime: got %h expected %h", obs[0], note_vec(1'b0, 4'd0, 1'b1, 7'd60, 7'd100));
        end
      end
      if (i >= 8) begin
        checks++;
        if (out_valid0 !== 1'b0) begin
          errors++; $display("[TB] FAIL interleave_cleared byte%0d: got %b expected 0", i, out_valid0);
        end
      end
    end
  endtask

  task automatic test_cc_filter;
    bit [7:0] seq [11] = '{8'hB2, 8'h18, 8'h40, 8'hB2, 8'h07, 8'h40, 8'hB0, 8'h07, 8'h40, 8'hC0, 8'h05};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send_byte(seq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++; $display("[TB] FAIL cc inst%0d byte%0d: got %h expected %h", k, i, obs[k], expv(k));
        end
      end
      if (i == 2) begin
        checks++;
        if (obs[0] !== {1'b1, 1'b0, 1'b1, 4'd2, 15'd0, 7'd24, 7'd64}) begin
          errors++; $display("[TB] FAIL cc_known: got %h expected %h", obs[0], {1'b1, 1'b0, 1'b1, 4'd2, 15'd0, 7'd24, 7'd64});
        end
      end
      if (i == 5) begin
        checks++;
        if (out_valid0 !== 1'b0) begin
          errors++; $display("[TB] FAIL cc_filtered: got %b expected 0", out_valid0);
        end
      end
      if (i == 8) begin
        checks++;
        if (obs[1] !== {1'b1, 1'b0, 1'b1, 4'd0, 15'd0, 7'd7, 7'd64}) begin
          errors++; $display("[TB] FAIL cc_unfiltered: got %h expected %h", obs[1], {1'b1, 1'b0, 1'b1, 4'd0, 15'd0, 7'd7, 7'd64});
        end
      end
    end
    checks++;
    if (dut0.state !== WAIT_D1 || out_valid0 !== 1'b0) begin
      errors++; $display("[TB] FAIL program_change: state %0d valid %b expected state %0d valid 0", dut0.state, out_valid0, WAIT_D1);
    end
  endtask

  task automatic test_backpressure;
    bit [7:0] seq [5] = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++; $display("[TB] FAIL backpressure inst%0d byte%0d: got %h expected %h", k, i, obs[k], expv(k));
        end
      end
    end
    checks++;
    if (obs[0] !== note_vec(1'b1, 4'd0, 1'b1, 7'd60, 7'd100)) begin
      errors++; $display("[TB] FAIL backpressure_hold: got %h expected %h", obs[0], note_vec(1'b1, 4'd0, 1'b1, 7'd60, 7'd100));
    end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    checks++;
    if (obs[0] !== note_vec(1'b0, 4'd0, 1'b1, 7'd60, 7'd100)) begin
      errors++; $display("[TB] FAIL overflow_clear: got %h expected %h", obs[0], note_vec(1'b0, 4'd0, 1'b1, 7'd60, 7'd100));
    end
  endtask

  task automatic test_back_to_back;
    send_byte(8'h3E);
    out_ready = 1'b1;
    send_byte(8'h70);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expv(k)) begin
        errors++; $display("[TB] FAIL back_to_back inst%0d: got %h expected %h", k, obs[k], expv(k));
      end
    end
    checks++;
    if (obs[0] !== note_vec(1'b0, 4'd0, 1'b1, 7'd62, 7'd112)) begin
      errors++; $display("[TB] FAIL back_to_back_event: got %h expected %h", obs[0], note_vec(1'b0, 4'd0, 1'b1, 7'd62, 7'd112));
    end
  endtask

  task automatic test_reset_mid_message;
    out_ready = 1'b0;
    send_byte(8'h40);
    send_byte(8'h50);
    send_byte(8'h90);
    send_byte(8'h3C);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 36'd0) begin
          errors++; $display("[TB] FAIL reset_mid_outputs inst%0d: got %h expected 0", k, obs[k]);
        end
      end
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_byte(8'h64);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 36'd0 || obs[k] !== expv(k)) begin
        errors++; $display("[TB] FAIL reset_mid_discard inst%0d: got %h expected %h", k, obs[k], expv(k));
      end
    end
  endtask

  task automatic test_random;
    bit [3:0] types [7] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      byte_data = {types[$urandom_range(0, 6)], 4'($urandom_range(0, 3))};
      else if (r < 16) byte_data = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 18) byte_data = 8'hF0;
      else if (r < 20) byte_data = 8'($urandom_range(8'hF1, 8'hF7));
      else if (r < 35) byte_data = 8'($urandom_range(20, 29));
      else if (r < 40) byte_data = 8'h00;
      else             byte_data = 8'($urandom_range(0, 127));
      byte_valid     = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      clear_overflow = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++; $display("[TB] FAIL random inst%0d step%0d: got %h expected %h", k, i, obs[k], expv(k));
        end
      end
    end
    byte_valid = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_running_status();
    test_interleave();
    test_cc_filter();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_message();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
